// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared header for the pipeline stall controller. It holds the mult/div timer states,
// latencies and op codes, and sits beside the forwarding-source selects.
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  localparam logic [1:0] FWD_SRC_RF = 2'd0;
  localparam logic [1:0] FWD_SRC_EM = 2'd1;
  localparam logic [1:0] FWD_SRC_MW = 2'd2;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // Divides take longer than multiplies, and signedness does not change the latency.
  function automatic logic [3:0] md_latency(input logic [1:0] op);
    return (op == MD_OP_DIV || op == MD_OP_DIVU) ? DIV_LAT : MULT_LAT;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Occupancy timer for the multiply/divide unit. It counts down the latency and
// pulses md_done in the last busy cycle.
module md_busy_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       md_start,
  input  logic [1:0] md_op,
  output logic       md_busy,
  output logic [3:0] md_cnt,
  output logic       md_done
);
  import pipe_stall_ctrl_pkg::*;

  md_state_t state;

  // A start that arrives while the unit is busy is dropped, so a running operation
  // always completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      md_cnt <= 4'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            state  <= MD_BUSY;
            md_cnt <= md_latency(md_op);
          end
        end
        MD_BUSY: begin
          if (md_cnt == 4'd1) begin
            state  <= MD_IDLE;
            md_cnt <= 4'd0;
          end else begin
            md_cnt <= md_cnt - 4'd1;
          end
        end
        default: begin
          state  <= MD_IDLE;
          md_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign md_busy = (state == MD_BUSY);
  assign md_done = md_busy && (md_cnt == 4'd1);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller. It merges D-stage data hazards with mult/div occupancy
// into the stage enables and the bubble insert, and counts stalled cycles.
module pipe_stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_data_stall,
  input  logic        D_md_use,
  input  logic        E_md_start,
  input  logic [1:0]  E_md_op,
  output logic        F_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        M_en,
  output logic        W_en,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic        md_done,
  output logic [15:0] stall_cnt
);
  import pipe_stall_ctrl_pkg::*;

  logic md_stall;
  logic stall;

  md_busy_timer u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (E_md_start),
    .md_op    (E_md_op),
    .md_busy  (md_busy),
    .md_cnt   (md_cnt),
    .md_done  (md_done)
  );

  // md_busy is still high in the md_done cycle, so a dependent mfhi/mflo is released
  // one cycle later, once HI/LO has been written.
  assign md_stall = D_md_use & (E_md_start | md_busy);
  assign stall    = D_data_stall | md_stall;

  assign F_en    = ~stall;
  assign D_en    = ~stall;
  assign E_flush = stall;
  assign M_en    = 1'b1;
  assign W_en    = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && stall_cnt != STALL_CNT_MAX) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl. It runs directed and random stimulus against a
// timeline model of multiply/divide occupancy and the count of stalled cycles.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        reset;
  logic        D_data_stall;
  logic        D_md_use;
  logic        E_md_start;
  logic [1:0]  E_md_op;
  logic        F_en;
  logic        D_en;
  logic        E_flush;
  logic        M_en;
  logic        W_en;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic        md_done;
  logic [15:0] stall_cnt;

  int check_count = 0;
  int error_count = 0;

  // An operation occupies cycles [op_start, op_start+op_len-1] of a global cycle index.
  int cycle_idx = 0;
  int op_start  = -1000;
  int op_len    = 0;
  int stall_ref = 0;
  int done_seen = 0;

  pipe_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .D_data_stall (D_data_stall),
    .D_md_use     (D_md_use),
    .E_md_start   (E_md_start),
    .E_md_op      (E_md_op),
    .F_en         (F_en),
    .D_en         (D_en),
    .E_flush      (E_flush),
    .M_en         (M_en),
    .W_en         (W_en),
    .md_busy      (md_busy),
    .md_cnt       (md_cnt),
    .md_done      (md_done),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit model_busy();
    return (cycle_idx >= op_start) && (cycle_idx < op_start + op_len);
  endfunction

  function automatic int model_cnt();
    return model_busy() ? (op_len - (cycle_idx - op_start)) : 0;
  endfunction

  function automatic bit model_stall();
    return D_data_stall | (D_md_use & (E_md_start | model_busy()));
  endfunction

  task automatic model_reset();
    op_start  = -1000;
    op_len    = 0;
    stall_ref = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      if (model_stall() && stall_ref < 65535) stall_ref++;
      if (E_md_start && !model_busy()) begin
        op_start = cycle_idx + 1;
        op_len   = E_md_op[1] ? 10 : 5;
      end
    end
    cycle_idx++;
  endtask

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    bit st;
    st = model_stall();
    checkOutput("F_en", F_en, !st);
    checkOutput("D_en", D_en, !st);
    checkOutput("E_flush", E_flush, st);
    checkOutput("M_en", M_en, 1);
    checkOutput("W_en", W_en, 1);
    checkOutput("md_busy", md_busy, model_busy());
    checkOutput("md_cnt", md_cnt, model_cnt());
    checkOutput("md_done", md_done, model_busy() && model_cnt() == 1);
    checkOutput("stall_cnt", stall_cnt, stall_ref);
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic applyStimulus(input logic ds, input logic mu, input logic st,
                               input logic [1:0] op, input bit do_check);
    D_data_stall = ds;
    D_md_use     = mu;
    E_md_start   = st;
    E_md_op      = op;
    #2;
    if (do_check) check_all();
    if (md_done) done_seen++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    D_data_stall = 1'b0;
    D_md_use     = 1'b0;
    E_md_start   = 1'b0;
    E_md_op      = 2'b00;
    #1;
    check_all();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    reset = 1'b1;

    // Mult latency with no dependent instruction in D
    done_seen = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    checkOutput("mult_first_cnt", md_cnt, 5);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("mult_done_pulses", done_seen, 1);
    checkOutput("mult_no_stall", stall_cnt, 0);

    // Dependent divu: the start cycle plus ten busy cycles are stalled
    pulse_reset();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("divu_stall_cnt", stall_cnt, 11);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("divu_released_stall_cnt", stall_cnt, 11);

    // Abort a div at md_cnt==6 by asserting reset between edges
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("abort_pre_cnt", md_cnt, 6);
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("abort_busy", md_busy, 0);
    checkOutput("abort_cnt", md_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("abort_no_done", done_seen, 0);

    // Data and md stalls asserted together count once per cycle
    pulse_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("double_stall_cnt", stall_cnt, 3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    // Random traffic, including starts while busy and occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) pulse_reset();
      applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), 1'b1);
    end

    // Saturation of the stalled-cycle counter
    pulse_reset();
    for (int i = 0; i < 65534; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("sat_preload", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("sat_hold", stall_cnt, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-003 D_data_stall  input  1  Tuse/Tnew hazard request from the D-stage hazard decoder.
REQ-004 D_md_use  input  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-005 E_md_start  input  1  instruction in E is mult/multu/div/divu and is valid (not a flushed bubble).
REQ-006 E_md_op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled only when E_md_start=1.
REQ-007 F_en  output  1  PC register write enable.
REQ-008 D_en  output  1  F/D pipeline register enable.
REQ-009 E_flush  output  1  D/E pipeline register synchronous clear (inserts a bubble).
REQ-010 M_en, W_en  output  1 each  E/M and M/W register enables; constant 1.
REQ-011 md_busy  output  1  multiply/divide unit occupied.
REQ-012 md_cnt  output  4  remaining busy cycles.
REQ-013 md_done  output  1  one-cycle pulse; HI/LO write strobe.
REQ-014 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-015 States: IDLE, BUSY; encoding comes from the shared header.
REQ-016 IDLE with E_md_start=1: next state BUSY; md_cnt loads 5 for mult/multu and 10 for div/divu.
REQ-017 BUSY: md_cnt decrements by 1 per cycle.
REQ-018 BUSY with md_cnt==1: md_done=1 (combinational) in that cycle; next state IDLE; md_cnt goes to 0.
REQ-019 Busy duration is exactly N cycles after the start edge (N=5 or 10); md_done occurs in the Nth cycle.
REQ-020 md_busy = (state==BUSY).
REQ-021 E_md_start while BUSY is ignored; state and md_cnt are unaffected. This cannot occur legally because of REQ-022.
REQ-022 md_stall = D_md_use & (E_md_start | md_busy).
REQ-023 stall = D_data_stall | md_stall.
REQ-024 F_en = D_en = ~stall; E_flush = stall; M_en = W_en = 1. These are combinational with no added latency.
REQ-025 In the md_done cycle md_busy is still 1, so a dependent mfhi/mflo remains stalled. It is released on the following cycle.
REQ-026 stall_cnt increments on every clock with stall=1 and saturates at 16'hFFFF.
REQ-027 D_data_stall and md_stall asserted together count as one stalled cycle.

Reset
REQ-028 reset=0 asynchronously sets state IDLE, md_cnt 0 and stall_cnt 0.
REQ-029 During reset, md_busy=0, md_done=0, F_en=D_en=~D_data_stall-derived value, and E_flush follows REQ-024.
REQ-030 Reset mid-operation aborts the operation: no md_done is generated, and the first edge after release behaves as IDLE.

Structure
REQ-031 State encodings, MULT_LAT=5, DIV_LAT=10 and md op codes live in the shared header, beside the forwarding-source select macros.
REQ-032 One sub-module is used: md_busy_timer, containing the state register, md_cnt, and md_done/md_busy generation.
REQ-033 All stall combine logic and stall_cnt live in the top level.
REQ-034 The block shall be 120-400 lines of RTL.

Verification
REQ-035 Mult latency: E_md_start=1, E_md_op=00 for one cycle. Required: md_busy high 5 cycles, md_cnt 5,4,3,2,1, md_done pulses in cycle 5 only.
REQ-036 Dependent divide: divu start, then D_md_use=1 held (mflo). Required: F_en=D_en=0 and E_flush=1 for the start cycle plus 10 busy cycles (11 stalled cycles); stall_cnt=11.
REQ-037 Independent instruction: mult start with D_md_use=0 throughout. Required: F_en stays 1, no stall, md_done still pulses after 5 cycles.
REQ-038 Abort: assert reset=0 at md_cnt=6 during div, without a clock edge. Required: md_busy=0 and md_cnt=0 immediately; no md_done after release.
REQ-039 Simultaneous stalls: D_data_stall=1 plus md_stall=1 for 3 cycles. Required: stall_cnt +3, not +6.
REQ-040 Saturation: preload stall_cnt to 16'hFFFE by forcing stall for 65534 cycles, then 3 more stall cycles. Required: stall_cnt holds 16'hFFFF.
